// File: rtl/c0_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional checksum support is selected by the C0_LOADER_CSUM_EN macro.
package c0_loader_pkg;

   // Receiver bit-level states.
   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   // Packet-level states.
   typedef enum logic [2:0] {
      P_MAGIC,
      P_LEN0,
      P_LEN1,
      P_DATA,
      P_WRITE,
      P_CSUM,
      P_DONE
   } pkt_state_t;

   localparam logic [7:0] MAGIC_BYTE = 8'hA5;
   localparam int         LEN_W      = 16;

endpackage

// File: rtl/c0_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting
// start detection. Emits a one-cycle byte_valid pulse (there is no ready: the
// consumer must take data while byte_valid is high, data then stays stable
// until the next byte) or a one-cycle frame_err pulse on a bad stop bit.
module c0_uart_rx
   import c0_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_meta;
   logic          rx_sync;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   // Two-flop synchroniser for the asynchronous pad; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // Receive FSM: half-bit start check, then one sample per bit period.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= R_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            R_IDLE: begin
               cnt <= '0;
               if (!rx_sync) state <= R_START;
            end
            R_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_sync ? R_IDLE : R_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_DATA: begin
               if (cnt == FULL_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= R_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_STOP: begin
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  state <= R_IDLE;
                  if (rx_sync) begin
                     data       <= shreg;
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/c0_uart_loader.sv
// Boot loader top: parses A5 / len16 / data-words packets from the UART and
// writes little-endian words to SRAM port 0 from address 0, holding the core
// in reset until the image is complete. Define C0_LOADER_CSUM_EN to require a
// trailing XOR checksum byte after the data.
module c0_uart_loader
   import c0_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_BITS    = 8
) (
   input  logic                 clk_g,
   input  logic                 rst_g,
   input  logic                 rx,
   output logic                 sram_csb0,
   output logic                 sram_web0,
   output logic [3:0]           sram_wmask0,
   output logic [ADDR_BITS-1:0] sram_addr0,
   output logic [31:0]          sram_din0,
   output logic                 core_rst_o,
   output logic                 load_done_o,
   output logic                 load_err_o
);

   localparam int          IW    = ADDR_BITS + 1;
   localparam logic [31:0] DEPTH = 32'd1 << ADDR_BITS;

   logic [7:0]       rx_data;
   logic             byte_valid;
   logic             frame_err;
   pkt_state_t       state;
   logic [7:0]       len_lo;
   logic [LEN_W-1:0] len_rx;
   logic [IW-1:0]    word_count;
   logic [IW-1:0]    word_idx;
   logic [IW-1:0]    idx_next;
   logic [1:0]       byte_idx;
   logic [23:0]      word_buf;
`ifdef C0_LOADER_CSUM_EN
   logic [7:0]       csum;
`endif

   c0_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk_g),
      .rst       (rst_g),
      .rx        (rx),
      .data      (rx_data),
      .byte_valid(byte_valid),
      .frame_err (frame_err)
   );

   // Length being received and next word index, used for decisions below.
   always_comb begin
      len_rx   = {rx_data, len_lo};
      idx_next = word_idx + IW'(1);
   end

   // Packet FSM with registered SRAM strobes and status outputs.
   always_ff @(posedge clk_g) begin
      if (rst_g) begin
         state       <= P_MAGIC;
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= 4'h0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         core_rst_o  <= 1'b1;
         load_done_o <= 1'b0;
         load_err_o  <= 1'b0;
         len_lo      <= '0;
         word_count  <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         word_buf    <= '0;
`ifdef C0_LOADER_CSUM_EN
         csum        <= '0;
`endif
      end else begin
         // Write strobe lasts exactly one cycle.
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= 4'h0;
         if (frame_err && state != P_DONE) begin
            // Drop the partial word; completed words stay in SRAM.
            state      <= P_MAGIC;
            load_err_o <= 1'b1;
         end else begin
            case (state)
               P_MAGIC: begin
                  if (byte_valid && rx_data == MAGIC_BYTE) begin
                     load_err_o <= 1'b0;
                     state      <= P_LEN0;
                  end
               end
               P_LEN0: begin
                  if (byte_valid) begin
                     len_lo <= rx_data;
                     state  <= P_LEN1;
                  end
               end
               P_LEN1: begin
                  if (byte_valid) begin
                     word_idx <= '0;
                     byte_idx <= '0;
`ifdef C0_LOADER_CSUM_EN
                     csum     <= '0;
`endif
                     if (len_rx == '0) begin
                        load_done_o <= 1'b1;
                        state       <= P_DONE;
                     end else if ({16'd0, len_rx} > DEPTH) begin
                        load_err_o <= 1'b1;
                        state      <= P_MAGIC;
                     end else begin
                        word_count <= len_rx[IW-1:0];
                        state      <= P_DATA;
                     end
                  end
               end
               P_DATA: begin
                  if (byte_valid) begin
                     byte_idx <= byte_idx + 1'b1;
`ifdef C0_LOADER_CSUM_EN
                     csum     <= csum ^ rx_data;
`endif
                     case (byte_idx)
                        2'd0: word_buf[7:0]   <= rx_data;
                        2'd1: word_buf[15:8]  <= rx_data;
                        2'd2: word_buf[23:16] <= rx_data;
                        default: begin
                           sram_csb0   <= 1'b0;
                           sram_web0   <= 1'b0;
                           sram_wmask0 <= 4'hF;
                           sram_addr0  <= word_idx[ADDR_BITS-1:0];
                           sram_din0   <= {rx_data, word_buf};
                           state       <= P_WRITE;
                        end
                     endcase
                  end
               end
               P_WRITE: begin
                  word_idx <= idx_next;
                  if (idx_next == word_count) begin
`ifdef C0_LOADER_CSUM_EN
                     state <= P_CSUM;
`else
                     load_done_o <= 1'b1;
                     state       <= P_DONE;
`endif
                  end else begin
                     state <= P_DATA;
                  end
               end
               P_CSUM: begin
`ifdef C0_LOADER_CSUM_EN
                  if (byte_valid) begin
                     if (rx_data == csum) begin
                        load_done_o <= 1'b1;
                        state       <= P_DONE;
                     end else begin
                        load_err_o <= 1'b1;
                        state      <= P_MAGIC;
                     end
                  end
`else
                  state <= P_MAGIC;
`endif
               end
               P_DONE: begin
                  // Release the core one cycle after load_done_o rises.
                  core_rst_o <= 1'b0;
               end
               default: state <= P_MAGIC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_c0_uart_loader.sv
// Self-checking bench for c0_uart_loader (CLKS_PER_BIT=4, ADDR_BITS=8).
// Checksum cases run when C0_LOADER_CSUM_EN is defined.
module tb_c0_uart_loader;

   localparam int CPB = 4;
   localparam int AB  = 8;

   logic          clk_g = 1'b0;
   logic          rst_g = 1'b1;
   logic          rx    = 1'b1;
   logic          sram_csb0;
   logic          sram_web0;
   logic [3:0]    sram_wmask0;
   logic [AB-1:0] sram_addr0;
   logic [31:0]   sram_din0;
   logic          core_rst_o;
   logic          load_done_o;
   logic          load_err_o;

   int            n_tests  = 0;
   int            n_fail   = 0;
   int            n_writes = 0;
   int            w0;
   int            done_cnt = 0;
   logic          prev_csb = 1'b1;
   logic [39:0]   exp_q[$];
   logic [31:0]   words_q[$];

   // clock
   always #5 clk_g = ~clk_g;

   c0_uart_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_BITS   (AB)
   ) dut (
      .clk_g      (clk_g),
      .rst_g      (rst_g),
      .rx         (rx),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_wmask0(sram_wmask0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .core_rst_o (core_rst_o),
      .load_done_o(load_done_o),
      .load_err_o (load_err_o)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard / monitor: SRAM writes and core release timing
   always @(negedge clk_g) begin
      if (sram_csb0 == 1'b0) begin
         n_writes <= n_writes + 1;
         check_val("wr_one_cycle", 64'(prev_csb), 64'd1);
         check_val("wr_web0", 64'(sram_web0), 64'd0);
         check_val("wr_wmask0", 64'(sram_wmask0), 64'hF);
         check_val("wr_pending", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) check_val("wr_addr_data", 64'({sram_addr0, sram_din0}), 64'(exp_q.pop_front()));
      end
      if (load_done_o && done_cnt == 0) check_val("core_rst_at_done", 64'(core_rst_o), 64'd1);
      if (load_done_o && done_cnt == 1) check_val("core_rst_after_done", 64'(core_rst_o), 64'd0);
      done_cnt <= load_done_o ? done_cnt + 1 : 0;
      prev_csb <= sram_csb0;
   end

   // driver tasks
   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk_g);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_ok);
      if (!stop_ok) repeat (12) send_bit(1'b1);
      send_bit(1'b1);
   endtask

   // Sends magic, length and the words in words_q; queues the expected writes.
   task automatic send_pkt();
      logic [7:0]  cs;
      logic [15:0] n;
      logic [31:0] w;
      cs = 8'h00;
      n  = 16'(words_q.size());
      send_byte(8'hA5);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      for (int i = 0; i < int'(n); i++) begin
         w = words_q[i];
         exp_q.push_back({8'(i), w});
         for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            cs = cs ^ w[8*k +: 8];
         end
      end
`ifdef C0_LOADER_CSUM_EN
      send_byte(cs);
`endif
      words_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_csb0"}, 64'(sram_csb0), 64'd1);
      check_val({tag, "_web0"}, 64'(sram_web0), 64'd1);
      check_val({tag, "_wmask0"}, 64'(sram_wmask0), 64'd0);
      check_val({tag, "_addr0"}, 64'(sram_addr0), 64'd0);
      check_val({tag, "_din0"}, 64'(sram_din0), 64'd0);
      check_val({tag, "_core_rst"}, 64'(core_rst_o), 64'd1);
      check_val({tag, "_done"}, 64'(load_done_o), 64'd0);
      check_val({tag, "_err"}, 64'(load_err_o), 64'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk_g);
      rst_g = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk_g);
      check_reset_outputs(tag);
      rst_g = 1'b0;
      @(negedge clk_g);
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && !load_done_o; i++) @(negedge clk_g);
      check_val({tag, "_done"}, 64'(load_done_o), 64'd1);
      repeat (2) @(negedge clk_g);
   endtask

   task automatic check_err_state(input string tag);
      check_val({tag, "_err"}, 64'(load_err_o), 64'd1);
      check_val({tag, "_done"}, 64'(load_done_o), 64'd0);
      check_val({tag, "_core_rst"}, 64'(core_rst_o), 64'd1);
   endtask

   // watchdog
   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // main sequence
   initial begin
      do_reset("reset0");

      // Two-word image.
      w0 = n_writes;
      words_q = '{32'h12345678, 32'hDEADBEEF};
      send_pkt();
      wait_done("two_words", 400);
      check_val("two_words_count", 64'(n_writes - w0), 64'd2);
      check_val("two_words_err", 64'(load_err_o), 64'd0);
      check_val("two_words_core_rst", 64'(core_rst_o), 64'd0);

      // Noise before magic, zero-length image.
      do_reset("reset1");
      w0 = n_writes;
      send_byte(8'h33);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      wait_done("zero_len", 400);
      check_val("zero_len_count", 64'(n_writes - w0), 64'd0);

      // Over-long length, then a valid packet clears the error.
      do_reset("reset2");
      w0 = n_writes;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h02);
      repeat (8) @(negedge clk_g);
      check_err_state("too_long");
      check_val("too_long_count", 64'(n_writes - w0), 64'd0);
      words_q = '{32'hCAFEF00D};
      send_pkt();
      wait_done("after_too_long", 400);
      check_val("after_too_long_err", 64'(load_err_o), 64'd0);

      // Framing error on the third data byte.
      do_reset("reset3");
      w0 = n_writes;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33, 1'b0);
      check_err_state("frame_err");
      check_val("frame_err_count", 64'(n_writes - w0), 64'd0);
      words_q = '{32'h0BADC0DE};
      send_pkt();
      wait_done("after_frame_err", 400);
      check_val("after_frame_err_err", 64'(load_err_o), 64'd0);

      // Reset in the middle of the second data byte.
      do_reset("reset4");
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h44);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst_g = 1'b1;
      @(negedge clk_g);
      check_reset_outputs("mid_rst");
      rst_g = 1'b0;
      rx    = 1'b1;
      repeat (12 * CPB) @(negedge clk_g);
      w0 = n_writes;
      words_q = '{32'h89ABCDEF};
      send_pkt();
      wait_done("after_mid_rst", 400);
      check_val("after_mid_rst_count", 64'(n_writes - w0), 64'd1);

`ifdef C0_LOADER_CSUM_EN
      // Good checksum.
      do_reset("reset5");
      exp_q.push_back({8'd0, 32'h08040201});
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0F);
      wait_done("csum_ok", 400);
      check_val("csum_ok_err", 64'(load_err_o), 64'd0);

      // Bad checksum: word is still written, load fails.
      do_reset("reset6");
      exp_q.push_back({8'd0, 32'h08040201});
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0E);
      repeat (8) @(negedge clk_g);
      check_err_state("csum_bad");
`endif

      repeat (4) @(negedge clk_g);
      check_val("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
